// File: rtl/danmaku_pkg.sv
// Shared types and constants for the overlay pattern datapath.
package danmaku_pkg;

  typedef enum logic [1:0] {SHOW, FADE_OUT, FADE_IN} seq_state_t;

  localparam logic [8:0] LEVEL_MAX = 9'd256;

  localparam int unsigned RGBA_W = 32;
  localparam int unsigned R_OFS  = 24;
  localparam int unsigned G_OFS  = 16;
  localparam int unsigned B_OFS  = 8;
  localparam int unsigned A_OFS  = 0;

endpackage

// File: rtl/frame_tick_gen.sv
// Frame-start detector: one-cycle registered pulse on the first cycle at the raster origin.
module frame_tick_gen #(
  parameter int unsigned CntW = 12
) (
  input  logic            pxlClk,
  input  logic            rst,
  input  logic [CntW-1:0] hcnt_i,
  input  logic [CntW-1:0] vcnt_i,
  output logic            frame_tick_o
);

  logic origin;
  logic origin_q;
  logic tick_q;

  assign origin = (hcnt_i == '0) && (vcnt_i == '0);

  // Only the rising edge of the origin condition counts, so a stalled raster ticks once.
  always_ff @(posedge pxlClk or negedge rst) begin
    if (!rst) begin
      origin_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      origin_q <= origin;
      tick_q   <= origin && !origin_q;
    end
  end

  assign frame_tick_o = tick_q;

endmodule

// File: rtl/overlay_sequencer.sv
// Frame-synchronous overlay source scheduler: dwell, fade out, switch source, fade in.
module overlay_sequencer
  import danmaku_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned FADE_STEP = 32,
  parameter int unsigned SEL_W     = $clog2(NUM_SRC)
) (
  input  logic                      pxlClk,
  input  logic                      rst,
  input  logic [11:0]               hcnt,
  input  logic [11:0]               vcnt,
  input  logic [RGBA_W*NUM_SRC-1:0] src_rgba,
  input  logic                      run,
  input  logic                      step,
  input  logic [15:0]               dwell_frames,
  output logic [7:0]                pixel_r_out,
  output logic [7:0]                pixel_g_out,
  output logic [7:0]                pixel_b_out,
  output logic [7:0]                pixel_a_out,
  output logic [SEL_W-1:0]          sel_out,
  output logic                      frame_tick,
  output logic                      busy
);

  localparam logic [9:0] StepW = 10'(FADE_STEP);

  seq_state_t       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d, sel_nxt;
  logic [8:0]       level_q, level_d, level_dn, level_up;
  logic [9:0]       level_up_sum;
  logic [15:0]      dwell_q, dwell_d, dwell_lim;
  logic [16:0]      dwell_inc;
  logic             pend_q, pend_d;
  logic             dwell_hit;

  logic [RGBA_W-1:0] src_word;
  logic [7:0]        a_scaled;
  logic [7:0]        pix_r_q, pix_g_q, pix_b_q, pix_a_q;

  frame_tick_gen #(
    .CntW(12)
  ) u_frame_tick_gen (
    .pxlClk      (pxlClk),
    .rst         (rst),
    .hcnt_i      (hcnt),
    .vcnt_i      (vcnt),
    .frame_tick_o(frame_tick)
  );

  always_comb begin
    dwell_lim    = (dwell_frames == 16'd0) ? 16'd1 : dwell_frames;
    dwell_inc    = {1'b0, dwell_q} + 17'd1;
    dwell_hit    = dwell_inc >= {1'b0, dwell_lim};
    level_dn     = ({1'b0, level_q} <= StepW) ? 9'd0 : level_q - StepW[8:0];
    level_up_sum = {1'b0, level_q} + StepW;
    level_up     = (level_up_sum >= {1'b0, LEVEL_MAX}) ? LEVEL_MAX : level_up_sum[8:0];
    sel_nxt      = (sel_q == SEL_W'(NUM_SRC - 1)) ? '0 : sel_q + SEL_W'(1);
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    level_d = level_q;
    dwell_d = dwell_q;
    pend_d  = pend_q;
    if (state_q == SHOW && step) pend_d = 1'b1;
    // A step arriving on the advancing tick itself is honoured via the direct step term.
    if (frame_tick && run) begin
      case (state_q)
        SHOW: begin
          if (dwell_hit || pend_q || step) begin
            state_d = FADE_OUT;
            dwell_d = '0;
            pend_d  = 1'b0;
          end else begin
            dwell_d = dwell_inc[15:0];
          end
        end
        FADE_OUT: begin
          level_d = level_dn;
          if (level_dn == 9'd0) begin
            state_d = FADE_IN;
            sel_d   = sel_nxt;
          end
        end
        FADE_IN: begin
          level_d = level_up;
          if (level_up == LEVEL_MAX) state_d = SHOW;
        end
        default: state_d = SHOW;
      endcase
    end
  end

  always_ff @(posedge pxlClk or negedge rst) begin
    if (!rst) begin
      state_q <= SHOW;
      sel_q   <= '0;
      level_q <= LEVEL_MAX;
      dwell_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      level_q <= level_d;
      dwell_q <= dwell_d;
      pend_q  <= pend_d;
    end
  end

  // Product bits [15:8]; level 256 yields src_a exactly.
  always_comb begin
    src_word = src_rgba[RGBA_W*sel_q +: RGBA_W];
    a_scaled = 8'((17'(src_word[A_OFS +: 8]) * 17'(level_q)) >> 8);
  end

  always_ff @(posedge pxlClk or negedge rst) begin
    if (!rst) begin
      pix_r_q <= '0;
      pix_g_q <= '0;
      pix_b_q <= '0;
      pix_a_q <= '0;
    end else begin
      pix_r_q <= src_word[R_OFS +: 8];
      pix_g_q <= src_word[G_OFS +: 8];
      pix_b_q <= src_word[B_OFS +: 8];
      pix_a_q <= a_scaled;
    end
  end

  assign pixel_r_out = pix_r_q;
  assign pixel_g_out = pix_g_q;
  assign pixel_b_out = pix_b_q;
  assign pixel_a_out = pix_a_q;
  assign sel_out     = sel_q;
  assign busy        = (state_q != SHOW);

endmodule

// File: tb/tb_overlay_sequencer.sv
// Directed-plus-random bench for overlay_sequencer against a per-frame behavioural model.
module tb_overlay_sequencer;

  localparam int NS    = 4;
  localparam int FS    = 64;
  localparam int SW    = 2;
  localparam int HW    = 8;
  localparam int VH    = 3;
  localparam int FRAME = HW * VH;

  logic              pxlClk = 1'b0;
  logic              rst;
  logic [11:0]       hcnt, vcnt;
  logic [32*NS-1:0]  src_rgba;
  logic              run, step;
  logic [15:0]       dwell_frames;
  logic [7:0]        pr, pg, pb, pa;
  logic [SW-1:0]     sel_out;
  logic              frame_tick, busy;

  always #5 pxlClk = ~pxlClk;

  overlay_sequencer #(
    .NUM_SRC  (NS),
    .FADE_STEP(FS),
    .SEL_W    (SW)
  ) dut (
    .pxlClk      (pxlClk),
    .rst         (rst),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .src_rgba    (src_rgba),
    .run         (run),
    .step        (step),
    .dwell_frames(dwell_frames),
    .pixel_r_out (pr),
    .pixel_g_out (pg),
    .pixel_b_out (pb),
    .pixel_a_out (pa),
    .sel_out     (sel_out),
    .frame_tick  (frame_tick),
    .busy        (busy)
  );

  int checks, failures;
  int h, v, obs_ticks, busy_ticks;
  bit stall_en;

  // Model: phase 0 = showing, 1 = fading out, 2 = fading in
  int m_phase, m_sel, m_level, m_dwell;
  bit m_pend, m_prev, m_tick;
  logic [7:0] e_r, e_g, e_b, e_a;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_sel = 0; m_level = 256; m_dwell = 0;
    m_pend = 0; m_prev = 0; m_tick = 0;
    e_r = 0; e_g = 0; e_b = 0; e_a = 0;
  endtask

  task automatic advance();
    int lim;
    case (m_phase)
      0: begin
        lim = (dwell_frames == 0) ? 1 : int'(dwell_frames);
        if (m_dwell + 1 >= lim || m_pend || step) begin
          m_phase = 1; m_dwell = 0; m_pend = 0;
        end else m_dwell++;
      end
      1: begin
        m_level = (m_level > FS) ? m_level - FS : 0;
        if (m_level == 0) begin m_phase = 2; m_sel = (m_sel + 1) % NS; end
      end
      default: begin
        m_level = (m_level + FS < 256) ? m_level + FS : 256;
        if (m_level == 256) m_phase = 0;
      end
    endcase
  endtask

  task automatic one_cycle();
    logic [31:0] w;
    bit origin;
    if (!rst) model_reset();
    else begin
      w   = src_rgba[m_sel*32 +: 32];
      e_r = w[31:24]; e_g = w[23:16]; e_b = w[15:8];
      e_a = 8'((int'(w[7:0]) * m_level) >> 8);
      if (m_tick && run) advance();
      else if (step && m_phase == 0) m_pend = 1;
      origin = (hcnt == 0) && (vcnt == 0);
      m_tick = origin && !m_prev;
      m_prev = origin;
    end
    @(posedge pxlClk); #1;
    chk("frame_tick", 32'(frame_tick), 32'(m_tick));
    chk("sel_out", 32'(sel_out), 32'(m_sel));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("pixel_r", 32'(pr), 32'(e_r));
    chk("pixel_g", 32'(pg), 32'(e_g));
    chk("pixel_b", 32'(pb), 32'(e_b));
    chk("pixel_a", 32'(pa), 32'(e_a));
    if (frame_tick) begin obs_ticks++; if (busy) busy_ticks++; end
  endtask

  task automatic drive();
    logic [7:0] a;
    hcnt = 12'(h); vcnt = 12'(v);
    for (int i = 0; i < NS; i++) begin
      case ($urandom_range(0, 3))
        0: a = 8'hFF;
        1: a = 8'h80;
        2: a = 8'h00;
        default: a = 8'($urandom);
      endcase
      src_rgba[i*32 +: 32] = {24'($urandom), a};
    end
  endtask

  task automatic adv_raster();
    if (stall_en && h == 0 && v == 0 && $urandom_range(0, 3) == 0) return;
    h++;
    if (h == HW) begin h = 0; v++; if (v == VH) v = 0; end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin drive(); one_cycle(); adv_raster(); end
  endtask

  initial begin
    checks = 0; failures = 0; stall_en = 0;
    rst = 1'b0; run = 1'b0; step = 1'b0; dwell_frames = 16'd2;
    h = 1; v = 0; src_rgba = '0; hcnt = '0; vcnt = '0;
    model_reset();
    run_cycles(3);
    rst = 1'b1; run = 1'b1;

    // Dwell 2 then an 8-tick fade that moves to source 1
    obs_ticks = 0; busy_ticks = 0;
    for (int i = 0; i < 40 * FRAME && obs_ticks < 12; i++) run_cycles(1);
    chk("dwell_ticks", 32'(obs_ticks), 32'd12);
    chk("busy_ticks", 32'(busy_ticks), 32'd8);
    chk("sel_after_fade", 32'(sel_out), 32'd1);

    // Asynchronous reset in the middle of a fade
    run_cycles(2 * FRAME + 5);
    rst = 1'b0; #1;
    chk("rst_r", 32'(pr), 32'd0);
    chk("rst_a", 32'(pa), 32'd0);
    chk("rst_sel", 32'(sel_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tick", 32'(frame_tick), 32'd0);
    model_reset();
    run_cycles(3);
    rst = 1'b1;
    run_cycles(2);
    chk("post_rst_sel", 32'(sel_out), 32'd0);

    // Freeze halfway through a fade out
    for (int i = 0; i < 40 * FRAME && !(m_phase == 1 && m_level == 128); i++) run_cycles(1);
    chk("reach_fade", 32'(busy), 32'd1);
    begin
      int snap_sel;
      snap_sel = m_sel;
      run = 1'b0; obs_ticks = 0;
      run_cycles(5 * FRAME);
      chk("freeze_ticks", 32'(obs_ticks), 32'd5);
      chk("freeze_sel", 32'(sel_out), 32'(snap_sel));
      chk("freeze_busy", 32'(busy), 32'd1);
      run = 1'b1;
    end

    // Step-driven advance up to source 3, then step wraps to 0
    dwell_frames = 16'd1000;
    for (int i = 0; i < 80 * FRAME && !(m_phase == 0 && m_sel == 3); i++) begin
      step = (m_phase == 0);
      run_cycles(1);
      step = 1'b0;
    end
    chk("reach_sel3", 32'(sel_out), 32'd3);
    run_cycles(FRAME);
    chk("hold_long_dwell", 32'(busy), 32'd0);
    step = 1'b1; run_cycles(1); step = 1'b0;
    obs_ticks = 0;
    for (int i = 0; i < 2 * FRAME && obs_ticks < 1; i++) run_cycles(1);
    run_cycles(1);
    chk("step_fade_start", 32'(busy), 32'd1);
    for (int i = 0; i < 12 * FRAME && m_phase != 0; i++) run_cycles(1);
    chk("wrap_sel", 32'(sel_out), 32'd0);
    chk("wrap_idle", 32'(busy), 32'd0);

    // Step while busy is ignored
    step = 1'b1; run_cycles(1); step = 1'b0;
    for (int i = 0; i < 3 * FRAME && m_phase == 0; i++) run_cycles(1);
    run_cycles(FRAME / 2);
    step = 1'b1; run_cycles(1); step = 1'b0;
    for (int i = 0; i < 12 * FRAME && m_phase != 0; i++) run_cycles(1);
    run_cycles(3 * FRAME);
    chk("busy_step_ignored", 32'(busy), 32'd0);
    chk("busy_step_sel", 32'(sel_out), 32'd1);

    // dwell 0 behaves as 1
    dwell_frames = 16'd0; obs_ticks = 0; busy_ticks = 0;
    for (int i = 0; i < 30 * FRAME && obs_ticks < 18; i++) run_cycles(1);
    chk("dwell0_busy", 32'(busy_ticks), 32'd16);
    chk("dwell0_sel", 32'(sel_out), 32'd3);

    // Random run/step/dwell with raster stalls at the origin
    stall_en = 1;
    for (int i = 0; i < 300 * FRAME; i++) begin
      if (i % 7 == 0) dwell_frames = 16'($urandom_range(0, 4));
      run  = ($urandom_range(0, 9) != 0);
      step = ($urandom_range(0, 39) == 0);
      run_cycles(1);
    end
    step = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/overlay_sequencer.md
Name: overlay_sequencer

Overview:
Frame-synchronous scheduler for the overlay pattern datapath. It selects one of NUM_SRC RGBA overlay sources and holds it for a programmable number of frames. It then fades that source's alpha to zero, switches to the next source at a frame boundary, and fades the new source back in. It sits between the pattern generators and the alpha compositor, and drives the pixel_*_out bus the compositor consumes.

Parameters:
NUM_SRC, 4, number of RGBA sources; must be 2..8.
FADE_STEP, 32, level change per frame during a fade; must be 1..256.
SEL_W, 2, width of sel_out; equals clog2(NUM_SRC).

Ports:
pxlClk  in  1  pixel clock, ≤165 MHz
rst  in  1  asynchronous, active-low reset
hcnt  in  12  current pixel column
vcnt  in  12  current pixel row
src_rgba  in  32*NUM_SRC  packed sources; source i occupies bits [32i+31:32i] as {r,g,b,a}
run  in  1  1 = frame-rate state advances; 0 = frame-rate state frozen
step  in  1  single-cycle pulse that requests early advance to the next source
dwell_frames  in  16  frames to hold in SHOW; 0 is treated as 1
pixel_r_out  out  8  selected red
pixel_g_out  out  8  selected green
pixel_b_out  out  8  selected blue
pixel_a_out  out  8  selected alpha scaled by fade level
sel_out  out  SEL_W  index of the current source
frame_tick  out  1  one-cycle pulse on the first cycle of each frame
busy  out  1  1 while in FADE_OUT or FADE_IN

Behaviour:
- frame_tick asserts when (hcnt==0 && vcnt==0) holds this cycle and did not hold the previous cycle. It is registered, so it appears one cycle after the origin pixel. It pulses regardless of run.
- Frame-rate state = FSM state, sel, level[8:0] (0..256), dwell counter[15:0]. It updates only on cycles where frame_tick=1 and run=1.
- FSM states and transitions:
  - SHOW: dwell increments each tick. When dwell+1 >= max(dwell_frames,1), or step_pending=1, go to FADE_OUT and clear dwell.
  - FADE_OUT: level <= level−FADE_STEP, saturating at 0. On the tick where the new level is 0, go to FADE_IN and set sel <= (sel==NUM_SRC−1) ? 0 : sel+1.
  - FADE_IN: level <= level+FADE_STEP, saturating at 256. On the tick where the new level is 256, go to SHOW.
- step_pending: set by step while in SHOW; cleared on entry to FADE_OUT. step is ignored while busy. A step on the same cycle as the consuming tick counts for that tick.
- Pixel path, latency exactly 1 cycle from src_rgba/hcnt to pixel_*_out:
  - r, g, b pass through from src_rgba[sel].
  - a_out = (src_a × level) >> 8, using a 17-bit product with bits [15:8] taken. level=256 forces a_out=src_a exactly.
- sel and level change only on the frame_tick cycle. The pixel path uses the values registered at that tick, so there is no mid-frame tearing.
- Reset (async, rst=0):
  - state=SHOW, sel=0, level=256, dwell=0, step_pending=0.
  - All outputs 0: pixel_*_out, sel_out, frame_tick, busy.
  - Reset mid-fade returns to these values immediately; there is no partial-fade recovery.
- dwell_frames change mid-SHOW takes effect at the next tick's compare. If the current dwell is already ≥ the new value, advance on that tick.

Decomposition:
- Shared package danmaku_pkg holds:
  - the seq_state_t enum {SHOW, FADE_OUT, FADE_IN};
  - LEVEL_MAX = 9'd256;
  - RGBA_W = 32 and the field offsets for r/g/b/a.
- One sub-module, frame_tick_gen: origin compare plus previous-state register, producing frame_tick. It is reusable by other overlay blocks.

Test Plan:
- Reset: assert rst=0 mid-frame -> all outputs 0. After release: sel_out=0, busy=0, and the first pixel shows level 256 (a_out=src_a).
- Dwell/fade sequence: NUM_SRC=4, FADE_STEP=64, dwell_frames=2, run=1 ->
  - SHOW for 2 ticks;
  - then levels 192, 128, 64, 0; sel 0→1 on the level-0 tick;
  - then 64, 128, 192, 256; SHOW; busy high for exactly 8 ticks.
- Alpha scaling: src_a=0xFF with level=128 -> a_out=0x7F. src_a=0x80 with level=256 -> 0x80. Any src_a with level=0 -> 0x00. RGB unchanged in all cases, with 1-cycle latency.
- Freeze: run=0 across 5 frame ticks mid-FADE_OUT -> level, sel and state are unchanged, while frame_tick still pulses 5 times.
- Step and wrap:
  - dwell_frames=1000 with step pulsed while sel=3 -> FADE_OUT starts at the next tick and sel wraps to 0.
  - step pulsed while busy -> ignored.
- dwell_frames=0 -> behaves as 1, so each source is held for one tick.
